// File: rtl/type_param_fifo_if.sv
// Handshake bundle for type_param_fifo: push side, pop side and status.
// slave  = the FIFO itself; master = the producer/consumer environment.
interface type_param_fifo_if #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          push_valid;
  logic          push_ready;
  T              push_data;
  logic          pop_valid;
  logic          pop_ready;
  T              pop_data;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  modport slave (
    input  push_valid, push_data, pop_ready,
    output push_ready, pop_valid, pop_data, count, full, empty
  );

  modport master (
    output push_valid, push_data, pop_ready,
    input  push_ready, pop_valid, pop_data, count, full, empty
  );
endinterface

// File: rtl/type_param_fifo.sv
// type_param_fifo: valid/ready FIFO carrying an opaque payload of type T.
// Register-array storage, DEPTH need not be a power of two (explicit pointer wrap).
// Optional macro TYPE_PARAM_FIFO_BYPASS_EN: when empty, a pushed item is presented
// on the pop side in the same cycle and is not stored if the consumer takes it.
module type_param_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  type_param_fifo_if.slave      bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          is_full;
  logic          is_empty;
  logic          bypass_take;
  logic          push_fire;
  logic          pop_fire;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Status flags and handshake decode; only registered state feeds ready/valid
  // except for the same-cycle bypass path when it is built in.
  always_comb begin
    is_full  = (count == CW'(DEPTH));
    is_empty = (count == '0);
    bus.push_ready = !is_full;
    bus.full       = is_full;
    bus.empty      = is_empty;
    bus.count      = count;
`ifdef TYPE_PARAM_FIFO_BYPASS_EN
    bus.pop_valid = !is_empty || bus.push_valid;
    bus.pop_data  = (is_empty && bus.push_valid) ? bus.push_data : mem[rd_ptr];
    bypass_take   = is_empty && bus.push_valid && bus.pop_ready;
`else
    bus.pop_valid = !is_empty;
    bus.pop_data  = mem[rd_ptr];
    bypass_take   = 1'b0;
`endif
    push_fire = bus.push_valid && !is_full && !bypass_take;
    pop_fire  = !is_empty && bus.pop_ready;
  end

  // Storage, pointers and occupancy; full blocks a push even when a pop fires.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) begin
        mem[wr_ptr] <= bus.push_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop_fire) rd_ptr <= ptr_next(rd_ptr);
      case ({push_fire, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_type_param_fifo.sv
// Directed bench for type_param_fifo: three instances (8-bit/depth 4,
// 32-bit/depth 3, packed struct/depth 3) sharing clock and reset.
module tb_type_param_fifo;
  typedef struct packed {
    logic       a;
    logic [3:0] b;
  } item_t;

  logic clk;
  logic rst;

  int n_cmp = 0;
  int n_bad = 0;

  type_param_fifo_if #(.T(logic [7:0]),  .DEPTH(4)) bus8 ();
  type_param_fifo_if #(.T(logic [31:0]), .DEPTH(3)) bus32 ();
  type_param_fifo_if #(.T(item_t),       .DEPTH(3)) buss ();

  type_param_fifo #(.T(logic [7:0]),  .DEPTH(4)) dut8  (.i_clk(clk), .i_rst(rst), .bus(bus8));
  type_param_fifo #(.T(logic [31:0]), .DEPTH(3)) dut32 (.i_clk(clk), .i_rst(rst), .bus(bus32));
  type_param_fifo #(.T(item_t),       .DEPTH(3)) duts  (.i_clk(clk), .i_rst(rst), .bus(buss));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports any mismatch.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sv(input item_t x);
    return {27'b0, x};
  endfunction

  initial begin
    rst = 1'b0;
    bus8.push_valid = 0;  bus8.push_data = '0;  bus8.pop_ready = 0;
    bus32.push_valid = 0; bus32.push_data = '0; bus32.pop_ready = 0;
    buss.push_valid = 0;  buss.push_data = '0;  buss.pop_ready = 0;
    #22 rst = 1'b1;
    step();

    // Reset state
    check("rst_empty",      32'(bus8.empty), 1);
    check("rst_count",      32'(bus8.count), 0);
    check("rst_push_ready", 32'(bus8.push_ready), 1);
    check("rst_pop_valid",  32'(bus8.pop_valid), 0);
    check("rst_pop_data",   32'(bus8.pop_data), 32'h00);
    check("rst_full",       32'(bus8.full), 0);

    // Fill depth-4 FIFO, overflow attempt, drain in order
    for (int i = 0; i < 4; i++) begin
      bus8.push_valid = 1; bus8.push_data = 8'(8'hA1 + i);
      step();
    end
    check("fill_count",      32'(bus8.count), 4);
    check("fill_full",       32'(bus8.full), 1);
    check("fill_push_ready", 32'(bus8.push_ready), 0);
    bus8.push_data = 8'hFF;
    step();
    check("ovf_count", 32'(bus8.count), 4);
    bus8.push_valid = 0;
    bus8.pop_ready  = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_valid", 32'(bus8.pop_valid), 1);
      check("drain_data",  32'(bus8.pop_data), 32'(8'hA1 + i));
      step();
    end
    check("drain_empty", 32'(bus8.empty), 1);
    check("drain_count", 32'(bus8.count), 0);
    step();
    check("underflow_count", 32'(bus8.count), 0);
    check("underflow_valid", 32'(bus8.pop_valid), 0);
    bus8.pop_ready = 0;

    // Depth 3: streaming with one item in flight, pointers wrap 2->0
    bus32.push_valid = 1; bus32.push_data = 0;
    #1 check("wrap_no_early_valid", 32'(bus32.pop_valid), 0);
    step();
    check("wrap_first_count", 32'(bus32.count), 1);
    bus32.pop_ready = 1;
    for (int i = 1; i < 10; i++) begin
      bus32.push_data = 32'(i);
      #1;
      check("wrap_data", bus32.pop_data, 32'(i - 1));
      step();
      check("wrap_count", 32'(bus32.count), 1);
    end
    bus32.push_valid = 0;
    #1 check("wrap_last", bus32.pop_data, 9);
    step();
    check("wrap_end_count", 32'(bus32.count), 0);
    bus32.pop_ready = 0;

    // Struct payload: full FIFO, simultaneous push+pop blocks the push
    buss.push_valid = 1;
    buss.push_data = '{a: 1'b1, b: 4'd1}; step();
    buss.push_data = '{a: 1'b0, b: 4'd2}; step();
    buss.push_data = '{a: 1'b1, b: 4'd3}; step();
    check("s_full_count", 32'(buss.count), 3);
    buss.push_data = '{a: 1'b0, b: 4'd4};
    buss.pop_ready = 1;
    #1;
    check("s_push_blocked", 32'(buss.push_ready), 0);
    check("s_head", sv(buss.pop_data), sv('{a: 1'b1, b: 4'd1}));
    step();
    check("s_count_after_pop", 32'(buss.count), 2);
    buss.pop_ready = 0;
    #1 check("s_push_ready", 32'(buss.push_ready), 1);
    step();
    check("s_count_refill", 32'(buss.count), 3);
    buss.push_valid = 0;
    buss.pop_ready = 1;
    #1 check("s_pop1", sv(buss.pop_data), sv('{a: 1'b0, b: 4'd2}));
    step();
    #1 check("s_pop2", sv(buss.pop_data), sv('{a: 1'b1, b: 4'd3}));
    step();
    #1 check("s_pop3", sv(buss.pop_data), sv('{a: 1'b0, b: 4'd4}));
    step();
    check("s_empty", 32'(buss.empty), 1);
    buss.pop_ready = 0;

    // Same-cycle bypass (or one-cycle latency without it)
    bus8.push_valid = 1; bus8.push_data = 8'h5C; bus8.pop_ready = 1;
    #1;
`ifdef TYPE_PARAM_FIFO_BYPASS_EN
    check("byp_valid", 32'(bus8.pop_valid), 1);
    check("byp_data",  32'(bus8.pop_data), 32'h5C);
    step();
    bus8.push_valid = 0; bus8.pop_ready = 0;
    check("byp_count", 32'(bus8.count), 0);
    #1 check("byp_after_valid", 32'(bus8.pop_valid), 0);
`else
    check("lat_valid0", 32'(bus8.pop_valid), 0);
    step();
    bus8.push_valid = 0; bus8.pop_ready = 0;
    #1;
    check("lat_valid1", 32'(bus8.pop_valid), 1);
    check("lat_data",   32'(bus8.pop_data), 32'h5C);
    check("lat_count",  32'(bus8.count), 1);
    bus8.pop_ready = 1;
    step();
    bus8.pop_ready = 0;
    check("lat_drained", 32'(bus8.count), 0);
`endif

    // Asynchronous reset mid-stream with two items held
    bus8.push_valid = 1;
    bus8.push_data = 8'h11; step();
    bus8.push_data = 8'h22; step();
    bus8.push_valid = 0;
    check("pre_rst_count", 32'(bus8.count), 2);
    #3 rst = 1'b0;
    #1;
    check("arst_count",      32'(bus8.count), 0);
    check("arst_empty",      32'(bus8.empty), 1);
    check("arst_pop_valid",  32'(bus8.pop_valid), 0);
    check("arst_push_ready", 32'(bus8.push_ready), 1);
    check("arst_pop_data",   32'(bus8.pop_data), 0);
    #2 rst = 1'b1;
    step();
    bus8.push_valid = 1; bus8.push_data = 8'h33;
    step();
    bus8.push_valid = 0; bus8.pop_ready = 1;
    #1;
    check("post_rst_valid", 32'(bus8.pop_valid), 1);
    check("post_rst_data",  32'(bus8.pop_data), 32'h33);
    step();
    check("post_rst_count", 32'(bus8.count), 0);
    bus8.pop_ready = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
